corelet_ctrl: RTL and testbench

Instruction sequencer that drives the 35-bit `inst` bus of the corelet and the X/P SRAM controls packed in it. A single `start` pulse runs one complete tile pass: kernel load, activation load, execute, drain, psum readout to PMEM. The sequence is weight-stationary (WS) or output-stationary (OS), selected by `mode`. The block sits between the top-level testbench/host and the core, and is the issuing end of the instruction word the corelet decodes.

---
 rtl/corelet_ctrl_pkg.sv | 47 ++++
 rtl/corelet_ctrl_phase_counter.sv | 35 +++
 rtl/corelet_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/corelet_ctrl_pkg.sv
// Shared definitions for the corelet instruction sequencer: state codes,
// instruction-word field positions and the idle word.
package corelet_pkg;

    localparam int LEN_BW = 11;
    localparam int CNT_W  = LEN_BW + 1;
    localparam int INST_W = 35;

    localparam int INST_LOAD     = 0;
    localparam int INST_EXEC     = 1;
    localparam int INST_L0_WR    = 2;
    localparam int INST_L0_RD    = 3;
    localparam int INST_IFIFO_WR = 4;
    localparam int INST_RSVD     = 5;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_AX_LSB   = 7;
    localparam int INST_WEN_X    = 18;
    localparam int INST_CEN_X    = 19;
    localparam int INST_AP_LSB   = 20;
    localparam int INST_WEN_P    = 31;
    localparam int INST_CEN_P    = 32;
    localparam int INST_ACC      = 33;
    localparam int INST_MODE     = 34;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_KFETCH = 4'd1;
    localparam state_t ST_KLOAD  = 4'd2;
    localparam state_t ST_KGAP   = 4'd3;
    localparam state_t ST_AFETCH = 4'd4;
    localparam state_t ST_EXEC   = 4'd5;
    localparam state_t ST_DRAIN  = 4'd6;
    localparam state_t ST_RDOUT  = 4'd7;
    localparam state_t ST_ACC    = 4'd8;
    localparam state_t ST_DONE   = 4'd9;

    // SRAM enables and write enables are active low, so idle holds them high.
    localparam logic [INST_W-1:0] IDLE_WORD =
        (INST_W'(1) << INST_WEN_X) | (INST_W'(1) << INST_CEN_X) |
        (INST_W'(1) << INST_WEN_P) | (INST_W'(1) << INST_CEN_P);

    function automatic logic [CNT_W-1:0] eff_len(input logic [LEN_BW-1:0] l);
        return (l == '0) ? CNT_W'(1) : CNT_W'(l);
    endfunction

endpackage

// File: rtl/corelet_ctrl_phase_counter.sv
// Loadable down-counter shared by all sequencer phases; tc flags zero.
module phase_counter
    import corelet_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic [W-1:0] next_count,
    output logic         tc
);

    always_comb begin
        next_count = count;
        if (load) begin
            next_count = load_value;
        end else if (count != '0) begin
            next_count = count - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet instruction sequencer: one start pulse runs a full WS/OS tile pass.
// Optional PMEM accumulate phase is built when CORELET_CTRL_ACC_EN is defined.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int row = 8,
    parameter int col = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [LEN_BW-1:0] len,
    input  logic [LEN_BW-1:0] x_base,
    input  logic [LEN_BW-1:0] p_base,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] KCNT    = CNT_W'(col);
    localparam logic [CNT_W-1:0] KCNT_M1 = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(row + col - 1);

    state_t            state;
    state_t            state_d;
    logic              mode_q;
    logic [CNT_W-1:0]  len_q;
    logic [LEN_BW-1:0] x_ptr;
    logic [LEN_BW-1:0] p_ptr;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_value;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  next_count;
    logic              tc;

    logic              start_acc;
    logic              mode_d;
    logic              x_rd_d;
    logic              x_wr_d;
    logic [LEN_BW-1:0] x_addr_d;
    logic              p_wr_d;
    logic              p_rd_d;
    logic              acc_d;
    logic [LEN_BW-1:0] p_addr_d;
    logic [INST_W-1:0] inst_d;

    phase_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .count      (count),
        .next_count (next_count),
        .tc         (tc)
    );

    assign start_acc = (state == ST_IDLE) && start;

    // Each phase loads its length minus one; it advances when the count hits zero.
    always_comb begin
        state_d   = state;
        cnt_load  = 1'b0;
        cnt_value = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_KFETCH;
                    cnt_load  = 1'b1;
                    cnt_value = KCNT;
                end
            end
            ST_KFETCH: begin
                if (tc) begin
                    cnt_load = 1'b1;
                    if (!mode_q) begin
                        state_d   = ST_KLOAD;
                        cnt_value = KCNT_M1;
                    end else begin
                        // OS skips the L0 kernel load but still waits out propagation.
                        state_d   = ST_KGAP;
                        cnt_value = GAP_M1;
                    end
                end
            end
            ST_KLOAD: begin
                if (tc) begin
                    state_d   = ST_KGAP;
                    cnt_load  = 1'b1;
                    cnt_value = GAP_M1;
                end
            end
            ST_KGAP: begin
                if (tc) begin
                    state_d   = ST_AFETCH;
                    cnt_load  = 1'b1;
                    cnt_value = len_q;
                end
            end
            ST_AFETCH: begin
                if (tc) begin
                    state_d   = ST_EXEC;
                    cnt_load  = 1'b1;
                    cnt_value = len_q - CNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (tc) begin
                    state_d   = ST_DRAIN;
                    cnt_load  = 1'b1;
                    cnt_value = GAP_M1;
                end
            end
            ST_DRAIN: begin
                if (tc) begin
                    state_d   = ST_RDOUT;
                    cnt_load  = 1'b1;
                    cnt_value = len_q;
                end
            end
            ST_RDOUT: begin
                if (tc) begin
                    cnt_load = 1'b1;
`ifdef CORELET_CTRL_ACC_EN
                    state_d   = ST_ACC;
                    cnt_value = len_q;
`else
                    state_d   = ST_DONE;
                    cnt_value = '0;
`endif
                end
            end
`ifdef CORELET_CTRL_ACC_EN
            ST_ACC: begin
                if (tc) begin
                    state_d   = ST_DONE;
                    cnt_load  = 1'b1;
                    cnt_value = '0;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-cycle values; SRAM writes echo the
    // read visible on inst this cycle, which covers the one-cycle read latency.
    assign mode_d   = start_acc ? mode : mode_q;
    assign x_rd_d   = ((state_d == ST_KFETCH) || (state_d == ST_AFETCH)) && (next_count != '0);
    assign x_addr_d = start_acc ? x_base : x_ptr;
    assign x_wr_d   = !inst[INST_CEN_X];
    assign p_wr_d   = inst[INST_OFIFO_RD];

`ifdef CORELET_CTRL_ACC_EN
    logic [LEN_BW-1:0] p_base_q;

    assign p_rd_d   = (state_d == ST_ACC) && (next_count != '0);
    assign acc_d    = !inst[INST_CEN_P] && inst[INST_WEN_P];
    assign p_addr_d = ((state_d == ST_ACC) && (state == ST_RDOUT)) ? p_base_q : p_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_base_q <= '0;
        end else if (start_acc) begin
            p_base_q <= p_base;
        end
    end
`else
    assign p_rd_d   = 1'b0;
    assign acc_d    = 1'b0;
    assign p_addr_d = p_ptr;
`endif

    always_comb begin
        inst_d = IDLE_WORD;
        if (state_d != ST_IDLE) begin
            inst_d[INST_MODE]     = mode_d;
            inst_d[INST_LOAD]     = (state_d == ST_KLOAD);
            inst_d[INST_EXEC]     = (state_d == ST_EXEC);
            inst_d[INST_L0_RD]    = !mode_d && ((state_d == ST_KLOAD) || (state_d == ST_EXEC));
            inst_d[INST_L0_WR]    = x_wr_d && !mode_d;
            inst_d[INST_IFIFO_WR] = x_wr_d && mode_d;
            inst_d[INST_OFIFO_RD] = (state_d == ST_RDOUT) && (next_count != '0);
            inst_d[INST_ACC]      = acc_d;
            if (x_rd_d) begin
                inst_d[INST_CEN_X]               = 1'b0;
                inst_d[INST_AX_LSB +: LEN_BW]    = x_addr_d;
            end
            if (p_wr_d || p_rd_d) begin
                inst_d[INST_CEN_P]               = 1'b0;
                inst_d[INST_WEN_P]               = !p_wr_d;
                inst_d[INST_AP_LSB +: LEN_BW]    = p_addr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            inst   <= IDLE_WORD;
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= 1'b0;
            len_q  <= CNT_W'(1);
            x_ptr  <= '0;
            p_ptr  <= '0;
        end else begin
            state <= state_d;
            inst  <= inst_d;
            busy  <= (state_d != ST_IDLE);
            done  <= (state_d == ST_DONE);
            if (start_acc) begin
                mode_q <= mode;
                len_q  <= eff_len(len);
                p_ptr  <= p_base;
            end
            if (x_rd_d) begin
                x_ptr <= x_addr_d + LEN_BW'(1);
            end
            if (p_wr_d || p_rd_d) begin
                p_ptr <= p_addr_d + LEN_BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: builds the expected per-cycle {done,busy,inst}
// timeline of each pass into a queue and compares it cycle by cycle.
module tb_corelet_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
`ifdef CORELET_CTRL_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [10:0] len;
    logic [10:0] x_base;
    logic [10:0] p_base;
    logic [34:0] inst;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];
    logic        pend_x;
    logic        pend_p;
    logic        pend_a;
    logic [10:0] pend_pa;

    always #5 clk = ~clk;

    corelet_ctrl #(.row(ROW), .col(COL)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .len    (len),
        .x_base (x_base),
        .p_base (p_base),
        .inst   (inst),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [34:0] base_word(input logic m);
        logic [34:0] w;
        w     = '0;
        w[18] = 1'b1;
        w[19] = 1'b1;
        w[31] = 1'b1;
        w[32] = 1'b1;
        w[34] = m;
        return w;
    endfunction

    // One cycle of the pass: cur holds this cycle's own actions; the writes
    // owed from the previous cycle's reads are merged in here.
    task automatic emit(input logic [34:0] cur, input logic m, input logic dn, input logic [10:0] pa);
        logic [34:0] w;
        w = cur;
        if (pend_x) begin
            if (m) w[4] = 1'b1;
            else   w[2] = 1'b1;
        end
        if (pend_p) begin
            w[32]    = 1'b0;
            w[31]    = 1'b0;
            w[30:20] = pend_pa;
        end
        if (pend_a) w[33] = 1'b1;
        exp_q.push_back({dn, 1'b1, w});
        pend_x  = !cur[19];
        pend_p  = cur[6];
        pend_pa = pa;
        pend_a  = !cur[32] && cur[31];
    endtask

    task automatic model_pass(input logic m, input int l, input logic [10:0] xb, input logic [10:0] pb,
                              input bit trail);
        logic [34:0] c;
        pend_x = 1'b0;
        pend_p = 1'b0;
        pend_a = 1'b0;
        pend_pa = '0;
        for (int k = 0; k <= COL; k++) begin
            c = base_word(m);
            if (k < COL) begin
                c[19]   = 1'b0;
                c[17:7] = xb + 11'(k);
            end
            emit(c, m, 1'b0, 11'd0);
        end
        if (!m) begin
            for (int k = 0; k < COL; k++) begin
                c    = base_word(m);
                c[0] = 1'b1;
                c[3] = 1'b1;
                emit(c, m, 1'b0, 11'd0);
            end
        end
        for (int k = 0; k < ROW + COL; k++) emit(base_word(m), m, 1'b0, 11'd0);
        for (int k = 0; k <= l; k++) begin
            c = base_word(m);
            if (k < l) begin
                c[19]   = 1'b0;
                c[17:7] = xb + 11'(COL + k);
            end
            emit(c, m, 1'b0, 11'd0);
        end
        for (int k = 0; k < l; k++) begin
            c    = base_word(m);
            c[1] = 1'b1;
            c[3] = !m;
            emit(c, m, 1'b0, 11'd0);
        end
        for (int k = 0; k < ROW + COL; k++) emit(base_word(m), m, 1'b0, 11'd0);
        for (int k = 0; k <= l; k++) begin
            c = base_word(m);
            if (k < l) c[6] = 1'b1;
            emit(c, m, 1'b0, pb + 11'(k));
        end
        if (ACC_EN) begin
            for (int k = 0; k <= l; k++) begin
                c = base_word(m);
                if (k < l) begin
                    c[32]    = 1'b0;
                    c[30:20] = pb + 11'(k);
                end
                emit(c, m, 1'b0, 11'd0);
            end
        end
        emit(base_word(m), m, 1'b1, 11'd0);
        if (trail) exp_q.push_back({2'b00, base_word(1'b0)});
    endtask

    function automatic int exp_latency(input logic m, input int l);
        return 1 + (COL + 1) + (m ? 0 : COL) + (ROW + COL) + (l + 1) + l + (ROW + COL) + (l + 1)
               + (ACC_EN ? l + 1 : 0) + 1;
    endfunction

    // Drives one start and walks the expected timeline; latency counts the
    // start cycle through the done cycle inclusive.
    task automatic run_pass(input string tag, input logic m, input logic [10:0] l,
                            input logic [10:0] xb, input logic [10:0] pb,
                            input int glitch_at, input int reset_at, input bit trail);
        int          le;
        int          cyc;
        int          done_cyc;
        logic [36:0] e;
        le = (l == 11'd0) ? 1 : int'(l);
        model_pass(m, le, xb, pb, trail);
        @(posedge clk); #1;
        start  = 1'b1;
        mode   = m;
        len    = l;
        x_base = xb;
        p_base = pb;
        cyc      = 0;
        done_cyc = -1;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            start  = 1'b0;
            mode   = 1'($urandom_range(0, 1));
            len    = 11'($urandom_range(0, 2047));
            x_base = 11'($urandom_range(0, 2047));
            p_base = 11'($urandom_range(0, 2047));
            if (cyc == glitch_at) start = 1'b1;
            e = exp_q.pop_front();
            check(tag, {done, busy, inst}, e);
            if (done && done_cyc < 0) done_cyc = cyc;
            if (cyc == reset_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                check({tag, "_rst"}, {done, busy, inst}, {2'b00, base_word(1'b0)});
                exp_q.delete();
            end
        end
        if (reset_at == 0) check({tag, "_lat"}, 37'(done_cyc + 1), 37'(exp_latency(m, le)));
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        len    = '0;
        x_base = '0;
        p_base = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_inst", 37'(inst), 37'(base_word(1'b0)));
        check("rst_busy", 37'(busy), 37'(0));
        check("rst_done", 37'(done), 37'(0));
        start = 1'b1;
        @(posedge clk); #1;
        check("rst_start_ignored", {done, busy, inst}, {2'b00, base_word(1'b0)});
        reset = 1'b0;
        start = 1'b0;

        run_pass("ws_len4", 1'b0, 11'd4, 11'd0, 11'd0, 0, 0, 1'b1);
        run_pass("os_len4", 1'b1, 11'd4, 11'd16, 11'd100, 0, 0, 1'b1);
        run_pass("ws_glitch", 1'b0, 11'd4, 11'd5, 11'd7, 40, 0, 1'b1);
        run_pass("ws_reset_drain", 1'b0, 11'd4, 11'd9, 11'd20, 0, 50, 1'b1);
        run_pass("ws_xwrap", 1'b0, 11'd4, 11'd2040, 11'd30, 0, 0, 1'b0);
        run_pass("os_b2b_len0", 1'b1, 11'd0, 11'd2045, 11'd2046, 0, 0, 1'b1);
        run_pass("ws_len2", 1'b0, 11'd2, 11'd3, 11'd2045, 0, 0, 1'b1);
        run_pass("os_len9", 1'b1, 11'd9, 11'd1000, 11'd2040, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
